intc_arb: RTL and testbench
===========================

INTC_ARB -- requirements
Module: intc_arb

Interface
REQ-001 SHALL have parameter NSRC, default 8, the number of interrupt sources (legal range 2..8).
REQ-002 SHALL have parameter A_IMSK, default 8'h3b, the mask register address.
REQ-003 SHALL have parameter A_IFLG, default 8'h3c, the pending-flag register address.
REQ-004 SHALL have parameter A_IVEC, default 8'h3d, the read-only vector/status register address.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port write, input, 1 bit: register write strobe.
REQ-008 SHALL have port read, input, 1 bit: register read strobe.
REQ-009 SHALL have port addr, input, 8 bits: register address.
REQ-010 SHALL have port wdata, input, 8 bits: write data.
REQ-011 SHALL have port rdata, output, 8 bits: combinational read data; 8'h00 when read=0 or the address does not match.
REQ-012 SHALL have port irq_src, input, NSRC bits: one-cycle event pulses from the timer/counter blocks (overflow, OCA and OCB, per timer).
REQ-013 SHALL have port status_reg_interrupt_enable, input, 1 bit: CPU global interrupt enable.
REQ-014 SHALL have port interrupt_request, output, 1 bit: request to the CPU, driven by a register.
REQ-015 SHALL have port interrupt_vector, output, 3 bits: index of the granted source, driven by a register.
REQ-016 SHALL have port interrupt_executed, input, 1 bit: CPU acknowledge, level.

Function
REQ-017 SHALL set IFLG[i] on the edge where irq_src[i]=1, regardless of IMSK.
REQ-018 SHALL clear IFLG bits by writing 1 to them at A_IFLG; writing 0 has no effect.
REQ-019 SHALL let a set from irq_src win over a software clear or an acknowledge of the same bit in the same cycle.
REQ-020 SHALL make IMSK read/write on bits [NSRC-1:0]; unused upper bits read 0.
REQ-021 SHALL read A_IVEC as {interrupt_request, state[1:0], 2'b0, interrupt_vector}.
REQ-022 SHALL implement an FSM with states IDLE=0, REQ=1 and ACK=2.
REQ-023 SHALL go IDLE->REQ when status_reg_interrupt_enable=1 and (IFLG & IMSK)!=0; on that edge it latches the winning index into interrupt_vector and sets interrupt_request=1, giving one cycle of latency from flag visible to request.
REQ-024 SHALL use fixed priority for the winner: the lowest set index wins.
REQ-025 SHALL, in REQ with interrupt_executed=1, clear IFLG[interrupt_vector], drop interrupt_request and go to ACK.
REQ-026 SHALL, in REQ with status_reg_interrupt_enable=0 or the latched source no longer pending-and-unmasked, drop interrupt_request and return to IDLE without clearing any flag.
REQ-027 SHALL hold interrupt_vector stable while in REQ; a higher-priority arrival does not preempt.
REQ-028 SHALL, in ACK, stay until interrupt_executed=0, then go to IDLE; one acknowledge never retires two events.
REQ-029 SHALL never assert interrupt_request in IDLE or ACK.
REQ-030 SHALL treat register writes as taking effect at the next edge, so arbitration in the same cycle uses the old values.

Reset
REQ-031 SHALL, with rst=1 at an edge, set IMSK=0, IFLG=0, state=IDLE, interrupt_request=0 and interrupt_vector=0, overriding every other event including a mid-handshake REQ or ACK.
REQ-032 SHALL ignore irq_src pulses coinciding with rst.

Configuration
REQ-033 SHALL support macro INTC_ROUND_ROBIN_EN: when defined, the winner is the first pending-unmasked index strictly after the last acknowledged index (modulo NSRC), and the last-acknowledged pointer resets to NSRC-1; when undefined, the fixed priority of REQ-024 applies and no pointer register exists.

Verification
REQ-034 SHALL cover: IMSK=8'h07, pulse irq_src[2] -> IFLG=8'h04 next cycle; interrupt_request=1 with vector 2 one cycle later; interrupt_executed=1 -> IFLG=0 and state ACK.
REQ-035 SHALL cover: irq_src[1] and irq_src[5] pulsed together with IMSK=8'hff -> vector 1 is served first, then vector 5 after interrupt_executed 1->0, then IFLG=0.
REQ-036 SHALL cover: status_reg_interrupt_enable=0 with a pending flag -> no request; when raised to 1 -> request asserted on the next edge.
REQ-037 SHALL cover: irq_src[3] pulse in the same cycle as the acknowledge of vector 3 -> IFLG[3] remains 1 and is re-requested after ACK.
REQ-038 SHALL cover: rst asserted while in REQ -> next edge interrupt_request=0, IMSK=0, IFLG=0 and A_IVEC reads 8'h00.
REQ-039 SHALL cover, with INTC_ROUND_ROBIN_EN defined: sources 0 and 1 pulsed continuously with IMSK=8'h03 -> vectors alternate 0,1,0,1.

Source files
------------

// File: rtl/intc_arb.sv
// Interrupt flag/mask registers with a single-request arbiter and CPU handshake.
// Optional build macro INTC_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module intc_arb #(
    parameter int         NSRC   = 8,
    parameter logic [7:0] A_IMSK = 8'h3b,
    parameter logic [7:0] A_IFLG = 8'h3c,
    parameter logic [7:0] A_IVEC = 8'h3d
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write,
    input  logic            read,
    input  logic [7:0]      addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    input  logic [NSRC-1:0] irq_src,
    input  logic            status_reg_interrupt_enable,
    output logic            interrupt_request,
    output logic [2:0]      interrupt_vector,
    input  logic            interrupt_executed
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            irq_q, irq_d;
    logic [2:0]      vec_q, vec_d;
    logic [NSRC-1:0] imsk_q, imsk_d;
    logic [NSRC-1:0] iflg_q, iflg_d;

    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] vec_onehot;
    logic            vec_pending;
    logic [2:0]      winner;
    logic            ack;

    assign interrupt_request = irq_q;
    assign interrupt_vector  = vec_q;

    assign pending     = iflg_q & imsk_q;
    assign vec_onehot  = {{(NSRC-1){1'b0}}, 1'b1} << vec_q;
    assign vec_pending = |(pending & vec_onehot);

`ifdef INTC_ROUND_ROBIN_EN
    logic [2:0] last_q, last_d;

    // Scan downward so the candidate closest after last_q is assigned last and wins.
    always_comb begin
        winner = '0;
        for (int k = NSRC; k >= 1; k--) begin
            if (pending[(int'(last_q) + k) % NSRC]) begin
                winner = 3'((int'(last_q) + k) % NSRC);
            end
        end
    end

    assign last_d = ack ? vec_q : last_q;
`else
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (status_reg_interrupt_enable && (|pending)) begin
                    state_d = ST_REQ;
                    irq_d   = 1'b1;
                    vec_d   = winner;
                end
            end
            ST_REQ: begin
                if (interrupt_executed) begin
                    ack     = 1'b1;
                    irq_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (!status_reg_interrupt_enable || !vec_pending) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!interrupt_executed) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    // Clears are applied before sets so a same-cycle source pulse always survives.
    always_comb begin
        imsk_d = imsk_q;
        iflg_d = iflg_q;
        if (write && (addr == A_IMSK)) begin
            imsk_d = wdata[NSRC-1:0];
        end
        if (write && (addr == A_IFLG)) begin
            iflg_d = iflg_d & ~wdata[NSRC-1:0];
        end
        if (ack) begin
            iflg_d = iflg_d & ~vec_onehot;
        end
        iflg_d = iflg_d | irq_src;
    end

    always_comb begin
        rdata = 8'h00;
        if (read) begin
            if (addr == A_IMSK) begin
                rdata = 8'(imsk_q);
            end else if (addr == A_IFLG) begin
                rdata = 8'(iflg_q);
            end else if (addr == A_IVEC) begin
                rdata = {irq_q, state_q, 2'b00, vec_q};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            vec_q   <= 3'd0;
            imsk_q  <= '0;
            iflg_q  <= '0;
`ifdef INTC_ROUND_ROBIN_EN
            last_q  <= 3'(NSRC - 1);
`endif
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            imsk_q  <= imsk_d;
            iflg_q  <= iflg_d;
`ifdef INTC_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_intc_arb.sv
// Directed bench for intc_arb: expected values are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_intc_arb;

    localparam logic [7:0] A_IMSK = 8'h3b;
    localparam logic [7:0] A_IFLG = 8'h3c;
    localparam logic [7:0] A_IVEC = 8'h3d;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] irq_src = 8'h00;
    logic       ie = 1'b0;
    logic       interrupt_request;
    logic [2:0] interrupt_vector;
    logic       interrupt_executed = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    intc_arb #(
        .NSRC   (8),
        .A_IMSK (A_IMSK),
        .A_IFLG (A_IFLG),
        .A_IVEC (A_IVEC)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .write                       (write),
        .read                        (read),
        .addr                        (addr),
        .wdata                       (wdata),
        .rdata                       (rdata),
        .irq_src                     (irq_src),
        .status_reg_interrupt_enable (ie),
        .interrupt_request           (interrupt_request),
        .interrupt_vector            (interrupt_vector),
        .interrupt_executed          (interrupt_executed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s observed %h but scoreboard empty", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s (%s) observed %h expected %h", tag, e.tag, obs, e.val);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        read = 1'b1;
        #1;
        d = rdata;
        read = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        write = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] a);
        logic [7:0] d;
        rd(a, d);
        check(tag, d);
    endtask

    initial begin
        logic [7:0] d;

        // Reset state
        tick();
        tick();
        push("ivec_rst", 8'h00);
        push("imsk_rst", 8'h00);
        push("iflg_rst", 8'h00);
        push("irq_rst", 8'h00);
        rst = 1'b0;
        tick();
        chk_reg("ivec_rst", A_IVEC);
        chk_reg("imsk_rst", A_IMSK);
        chk_reg("iflg_rst", A_IFLG);
        check("irq_rst", 8'(interrupt_request));

        // Basic flow: single source through the full handshake
        ie = 1'b1;
        wr(A_IMSK, 8'h07);
        push("imsk_rw", 8'h07);
        chk_reg("imsk_rw", A_IMSK);
        irq_src = 8'h04;
        push("iflg_set", 8'h04);
        push("irq_latency", 8'h00);
        tick();
        irq_src = 8'h00;
        chk_reg("iflg_set", A_IFLG);
        check("irq_latency", 8'(interrupt_request));
        push("irq_req", 8'h01);
        push("vec_req", 8'h02);
        push("ivec_req", 8'ha2);
        push("rdata_noread", 8'h00);
        tick();
        check("irq_req", 8'(interrupt_request));
        check("vec_req", 8'(interrupt_vector));
        chk_reg("ivec_req", A_IVEC);
        addr = A_IVEC;
        #1;
        check("rdata_noread", rdata);
        interrupt_executed = 1'b1;
        push("iflg_ack", 8'h00);
        push("ivec_ack", 8'h42);
        tick();
        chk_reg("iflg_ack", A_IFLG);
        chk_reg("ivec_ack", A_IVEC);
        interrupt_executed = 1'b0;
        push("ivec_idle", 8'h02);
        tick();
        chk_reg("ivec_idle", A_IVEC);

        // Two simultaneous sources: lowest index first
        wr(A_IMSK, 8'hff);
        irq_src = 8'h22;
        push("iflg_two", 8'h22);
        tick();
        irq_src = 8'h00;
        chk_reg("iflg_two", A_IFLG);
        push("vec_first", 8'h01);
        tick();
        check("vec_first", 8'(interrupt_vector));
        interrupt_executed = 1'b1;
        push("iflg_after_first", 8'h20);
        tick();
        chk_reg("iflg_after_first", A_IFLG);
        interrupt_executed = 1'b0;
        tick();
        push("ivec_second", 8'ha5);
        tick();
        chk_reg("ivec_second", A_IVEC);
        interrupt_executed = 1'b1;
        tick();
        interrupt_executed = 1'b0;
        push("iflg_two_done", 8'h00);
        tick();
        chk_reg("iflg_two_done", A_IFLG);

        // Global enable gating, withdrawal and software clear semantics
        ie = 1'b0;
        irq_src = 8'h10;
        tick();
        irq_src = 8'h00;
        tick();
        push("irq_ie_off", 8'h00);
        tick();
        check("irq_ie_off", 8'(interrupt_request));
        ie = 1'b1;
        push("ivec_ie_on", 8'ha4);
        tick();
        chk_reg("ivec_ie_on", A_IVEC);
        ie = 1'b0;
        push("ivec_withdraw", 8'h04);
        push("iflg_withdraw", 8'h10);
        tick();
        chk_reg("ivec_withdraw", A_IVEC);
        chk_reg("iflg_withdraw", A_IFLG);
        wr(A_IFLG, 8'hef);
        push("iflg_write0", 8'h10);
        chk_reg("iflg_write0", A_IFLG);
        wr(A_IFLG, 8'h10);
        push("iflg_write1", 8'h00);
        chk_reg("iflg_write1", A_IFLG);
        ie = 1'b1;

        // Source pulse coinciding with its own acknowledge
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        push("vec3_req", 8'h03);
        tick();
        check("vec3_req", 8'(interrupt_vector));
        interrupt_executed = 1'b1;
        irq_src = 8'h08;
        push("iflg_set_wins", 8'h08);
        push("ivec_ack3", 8'h43);
        tick();
        irq_src = 8'h00;
        chk_reg("iflg_set_wins", A_IFLG);
        chk_reg("ivec_ack3", A_IVEC);
        interrupt_executed = 1'b0;
        tick();
        push("ivec_rereq3", 8'ha3);
        tick();
        chk_reg("ivec_rereq3", A_IVEC);
        interrupt_executed = 1'b1;
        tick();
        interrupt_executed = 1'b0;
        tick();

        // Mask write and arbitration in the same cycle use the old mask
        wr(A_IMSK, 8'h00);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        write = 1'b1;
        addr = A_IMSK;
        wdata = 8'h01;
        push("irq_old_mask", 8'h00);
        tick();
        write = 1'b0;
        check("irq_old_mask", 8'(interrupt_request));
        push("ivec_new_mask", 8'ha0);
        tick();
        chk_reg("ivec_new_mask", A_IVEC);

        // Reset in the middle of a request, with a coincident source pulse
        wr(A_IMSK, 8'hff);
        rst = 1'b1;
        irq_src = 8'h41;
        push("irq_mid_rst", 8'h00);
        push("imsk_mid_rst", 8'h00);
        push("iflg_mid_rst", 8'h00);
        push("ivec_mid_rst", 8'h00);
        tick();
        irq_src = 8'h00;
        check("irq_mid_rst", 8'(interrupt_request));
        chk_reg("imsk_mid_rst", A_IMSK);
        chk_reg("iflg_mid_rst", A_IFLG);
        chk_reg("ivec_mid_rst", A_IVEC);
        rst = 1'b0;
        tick();

`ifdef INTC_ROUND_ROBIN_EN
        // Round-robin: two always-pending sources alternate starting at 0
        wr(A_IMSK, 8'h03);
        irq_src = 8'h03;
        tick();
        for (int n = 0; n < 4; n++) begin
            push("rr_vec", 8'(n % 2));
            tick();
            check("rr_vec", 8'(interrupt_vector));
            interrupt_executed = 1'b1;
            tick();
            interrupt_executed = 1'b0;
            tick();
        end
        irq_src = 8'h00;
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain observed %0d leftover expected 0", sb.size());
        end
        d = 8'h00;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
